// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline register / forwarding chain.
//   pipe_entry_t : entry layout {valid, regwe, rdy, a3, data, pc} at the
//                  default widths (the parametrised modules mirror it locally)
//   Q_SEL_RF     : lookup select value meaning "no forward, use regfile"
//   sel_w()      : width of a lookup select for a given number of stages
package pipe_pkg;

    localparam int unsigned PIPE_DATA_W = 32;
    localparam int unsigned PIPE_ADDR_W = 5;
    localparam int unsigned PIPE_PC_W   = 32;

    localparam int unsigned Q_SEL_RF = 0;

    typedef struct packed {
        logic                   valid;
        logic                   regwe;
        logic                   rdy;
        logic [PIPE_ADDR_W-1:0] a3;
        logic [PIPE_DATA_W-1:0] data;
        logic [PIPE_PC_W-1:0]   pc;
    } pipe_entry_t;

    // Select encodes 0 = regfile, k = stage k-1, so it needs STAGES+1 codes.
    function automatic int unsigned sel_w(input int unsigned stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/pipe_fwd_lookup.sv
// pipe_fwd_lookup: one forwarding lookup port over the effective entries.
//   q_addr            in   source register address (0 never matches)
//   e_valid/e_regwe   in   per-entry valid and regfile-write flags
//   e_rdy             in   per-entry effective ready
//   e_a3              in   per-entry destination, slice i = entry i
//   e_data            in   per-entry effective data, slice i = entry i
//   q_hit             out  a matching entry exists
//   q_sel             out  0 = regfile, k = entry k-1
//   q_data            out  forwarded data (0 when no hit or not ready)
//   q_pending         out  the winning match is not ready yet
module pipe_fwd_lookup
    import pipe_pkg::*;
#(
    parameter int unsigned STAGES = 3,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SEL_W  = 2
) (
    input  logic [ADDR_W-1:0]        q_addr,
    input  logic [STAGES-1:0]        e_valid,
    input  logic [STAGES-1:0]        e_regwe,
    input  logic [STAGES-1:0]        e_rdy,
    input  logic [STAGES*ADDR_W-1:0] e_a3,
    input  logic [STAGES*DATA_W-1:0] e_data,
    output logic                     q_hit,
    output logic [SEL_W-1:0]         q_sel,
    output logic [DATA_W-1:0]        q_data,
    output logic                     q_pending
);

    // Ascending scan, first match latched: entry 0 (youngest) wins.
    always_comb begin
        q_hit     = 1'b0;
        q_sel     = SEL_W'(Q_SEL_RF);
        q_data    = '0;
        q_pending = 1'b0;
        if (q_addr != '0) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                if (!q_hit && e_valid[i] && e_regwe[i] &&
                    (e_a3[i*ADDR_W +: ADDR_W] == q_addr)) begin
                    q_hit     = 1'b1;
                    q_sel     = SEL_W'(i + 1);
                    q_pending = ~e_rdy[i];
                    if (e_rdy[i]) begin
                        q_data = e_data[i*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/pipe_fwd_chain.sv
// pipe_fwd_chain: parametrised pipeline register chain with forwarding.
// Entry 0 is youngest; entry STAGES-1 presents the retire/write-back port.
// Optional feature macro: PIPE_PERF_CNT_EN (stall / retire counters).
//   clk, reset        rising-edge clock, synchronous active-low reset
//   in_*              issue request and entry fields; in_ready = ~stall
//   ext_stall         external stall request
//   flush             per-stage clear of the next entry value
//   upd_valid/data    late result delivery per stage
//   q_addr/hit/sel/data, hazard   NSRC forwarding lookups
//   wb_we/a3/data/pc  retire port to the regfile
//   err_unready       sticky: a writing entry retired without data
//   perf_*_cnt        performance counters (0 when feature disabled)
module pipe_fwd_chain
    import pipe_pkg::*;
#(
    parameter  int unsigned STAGES = 3,
    parameter  int unsigned NSRC   = 2,
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned ADDR_W = 5,
    parameter  int unsigned PC_W   = 32,
    localparam int unsigned SEL_W  = sel_w(STAGES)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [ADDR_W-1:0]        in_a3,
    input  logic                     in_regwe,
    input  logic                     in_rdy,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [PC_W-1:0]          in_pc,
    output logic                     in_ready,
    input  logic                     ext_stall,
    input  logic [STAGES-1:0]        flush,
    input  logic [STAGES-1:0]        upd_valid,
    input  logic [STAGES*DATA_W-1:0] upd_data,
    input  logic [NSRC*ADDR_W-1:0]   q_addr,
    output logic [NSRC-1:0]          q_hit,
    output logic [NSRC*SEL_W-1:0]    q_sel,
    output logic [NSRC*DATA_W-1:0]   q_data,
    output logic                     hazard,
    output logic                     wb_we,
    output logic [ADDR_W-1:0]        wb_a3,
    output logic [DATA_W-1:0]        wb_data,
    output logic [PC_W-1:0]          wb_pc,
    output logic                     err_unready,
    output logic [31:0]              perf_stall_cnt,
    output logic [31:0]              perf_retire_cnt
);

    // Same layout as pipe_entry_t, at this instance's widths.
    typedef struct packed {
        logic              valid;
        logic              regwe;
        logic              rdy;
        logic [ADDR_W-1:0] a3;
        logic [DATA_W-1:0] data;
        logic [PC_W-1:0]   pc;
    } entry_t;

    entry_t ent [STAGES];
    entry_t eff [STAGES];
    entry_t nxt [STAGES];
    entry_t rt;

    logic [STAGES-1:0]        ev_valid;
    logic [STAGES-1:0]        ev_regwe;
    logic [STAGES-1:0]        ev_rdy;
    logic [STAGES*ADDR_W-1:0] ev_a3;
    logic [STAGES*DATA_W-1:0] ev_data;
    logic [NSRC-1:0]          pend;
    logic                     stall;
    logic                     accept;
    logic                     rt_claims;

    // Effective entries: a same-cycle update makes the data final.
    always_comb begin
        ev_valid = '0;
        ev_regwe = '0;
        ev_rdy   = '0;
        ev_a3    = '0;
        ev_data  = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            eff[i] = ent[i];
            if (upd_valid[i] && ent[i].valid) begin
                eff[i].rdy  = 1'b1;
                eff[i].data = upd_data[i*DATA_W +: DATA_W];
            end
            ev_valid[i]                 = eff[i].valid;
            ev_regwe[i]                 = eff[i].regwe;
            ev_rdy[i]                   = eff[i].rdy;
            ev_a3[i*ADDR_W +: ADDR_W]   = eff[i].a3;
            ev_data[i*DATA_W +: DATA_W] = eff[i].data;
        end
    end

    for (genvar g = 0; g < NSRC; g++) begin : g_lookup
        pipe_fwd_lookup #(
            .STAGES (STAGES),
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W),
            .SEL_W  (SEL_W)
        ) u_lookup (
            .q_addr    (q_addr[g*ADDR_W +: ADDR_W]),
            .e_valid   (ev_valid),
            .e_regwe   (ev_regwe),
            .e_rdy     (ev_rdy),
            .e_a3      (ev_a3),
            .e_data    (ev_data),
            .q_hit     (q_hit[g]),
            .q_sel     (q_sel[g*SEL_W +: SEL_W]),
            .q_data    (q_data[g*DATA_W +: DATA_W]),
            .q_pending (pend[g])
        );
    end

    assign hazard   = |pend;
    assign stall    = hazard | ext_stall;
    assign in_ready = ~stall;
    assign accept   = in_valid & ~stall;

    // Stall only blocks issue (bubble into entry 0); older entries keep
    // draining. Flush is applied last so it overrides both shift and issue.
    always_comb begin
        nxt[0] = '0;
        if (accept) begin
            nxt[0].valid = 1'b1;
            nxt[0].regwe = in_regwe;
            nxt[0].rdy   = in_rdy;
            nxt[0].a3    = in_a3;
            nxt[0].data  = in_data;
            nxt[0].pc    = in_pc;
        end
        for (int unsigned i = 1; i < STAGES; i++) begin
            nxt[i] = eff[i-1];
        end
        for (int unsigned i = 0; i < STAGES; i++) begin
            if (flush[i]) begin
                nxt[i].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < STAGES; i++) begin
            if (!reset) begin
                ent[i] <= '0;
            end else begin
                ent[i] <= nxt[i];
            end
        end
    end

    // Retire port; gated by reset so nothing is written in a reset cycle.
    assign rt        = eff[STAGES-1];
    assign rt_claims = rt.valid & rt.regwe & (rt.a3 != '0);
    assign wb_we     = reset & rt_claims & rt.rdy;
    assign wb_a3     = rt.a3;
    assign wb_data   = rt.data;
    assign wb_pc     = rt.pc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_unready <= 1'b0;
        end else if (rt_claims && !rt.rdy) begin
            err_unready <= 1'b1;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] retire_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (in_valid && stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (rt.valid) begin
                retire_cnt <= retire_cnt + 32'd1;
            end
        end
    end

    assign perf_stall_cnt  = stall_cnt;
    assign perf_retire_cnt = retire_cnt;
`else
    assign perf_stall_cnt  = '0;
    assign perf_retire_cnt = '0;
`endif

endmodule
